// File: rtl/mod_unit.sv
// Sequential 32-bit unsigned modulo unit: radix-16 restoring shift-subtract,
// 4 remainder bits per clock, restarting whenever the operand inputs change.
module mod_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] q;
    logic [31:0] q_step;
    logic [32:0] r;
    logic [32:0] r_step;
    logic [2:0]  cnt;
    logic        mismatch;
    logic        load;
    logic        advance;
    logic        done;

    assign mismatch = (a != opa) || (b != opb);

    // Four chained restoring sub-steps; r keeps a 33rd bit so opb >= 2^31 cannot overflow the shift.
    always_comb begin
        r_step = r;
        q_step = q;
        for (int i = 0; i < 4; i++) begin
            r_step = {r_step[31:0], q_step[31]};
            q_step = {q_step[30:0], 1'b0};
            if (r_step >= {1'b0, opb}) begin
                r_step = r_step - {1'b0, opb};
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (mismatch) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (mismatch) begin
                    load = 1'b1;
                end else begin
                    advance = 1'b1;
                    if (cnt == 3'd7) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opa    <= 32'd0;
            opb    <= 32'd0;
            r      <= 33'd0;
            q      <= 32'd0;
            cnt    <= 3'd0;
            result <= 32'd0;
        end else if (load) begin
            opa <= a;
            opb <= b;
            q   <= a;
            r   <= 33'd0;
            cnt <= 3'd0;
        end else if (advance) begin
            r   <= r_step;
            q   <= q_step;
            cnt <= cnt + 3'd1;
            if (done) begin
                result <= r_step[31:0];
            end
        end
    end

endmodule

// File: tb/tb_mod_unit.sv
// Self-checking bench for mod_unit: directed scenarios plus random operand
// sequences, compared every cycle against a transaction-level latency model.
module tb_mod_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    // Reference model: operands seen, cycles still to wait, and the answer via plain %.
    logic [31:0] m_opa    = 32'd0;
    logic [31:0] m_opb    = 32'd0;
    logic [31:0] m_result = 32'd0;
    int          m_left   = 0;
    bit          m_busy   = 1'b0;

    always #5 clk = ~clk;

    mod_unit dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .result(result)
    );

    task automatic modelEdge();
        if (reset) begin
            m_opa    = 32'd0;
            m_opb    = 32'd0;
            m_result = 32'd0;
            m_busy   = 1'b0;
            m_left   = 0;
        end else if (a != m_opa || b != m_opb) begin
            m_opa  = a;
            m_opb  = b;
            m_busy = 1'b1;
            m_left = 8;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_result = (m_opb == 32'd0) ? m_opa : (m_opa % m_opb);
                m_busy   = 1'b0;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (result === m_result) else begin
            errors++;
            $error("FAIL %s: result=%0h expected=%0h", tag, result, m_result);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] exp);
        checks++;
        assert (result === exp) else begin
            errors++;
            $error("FAIL %s: result=%0h expected=%0h", tag, result, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, then check at the falling edge.
    task automatic applyStimulus(input logic rst, input logic [31:0] na, input logic [31:0] nb,
                                 input string tag);
        reset = rst;
        a     = na;
        b     = nb;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic holdCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, a, b, tag);
        end
    endtask

    initial begin
        int          changes;
        int          hold;
        logic [31:0] prev;
        logic [31:0] ra;
        logic [31:0] rb;

        applyStimulus(1'b1, 32'd0, 32'd0, "reset");
        applyStimulus(1'b1, 32'd0, 32'd0, "reset");
        checkValue("reset_value", 32'd0);
        holdCycles(3, "idle_after_reset");
        checkValue("no_start_zero_ops", 32'd0);

        // Basic: 25 mod 8, result only after 9 edges from capture
        applyStimulus(1'b0, 32'd25, 32'd8, "basic_capture");
        holdCycles(7, "basic_wait");
        checkValue("basic_not_yet", 32'd0);
        holdCycles(1, "basic_done");
        checkValue("basic_value", 32'd1);
        holdCycles(4, "basic_hold");

        // Restart on each operand change
        applyStimulus(1'b1, 32'd0, 32'd0, "reset2");
        applyStimulus(1'b0, 32'd25, 32'd8, "restart_a");
        applyStimulus(1'b0, 32'd40, 32'd8, "restart_b");
        applyStimulus(1'b0, 32'd40, 32'd12, "restart_c");
        holdCycles(10, "restart_wait");
        checkValue("restart_value", 32'd4);

        // Reset in the middle of an operation
        applyStimulus(1'b0, 32'd30, 32'd10, "midreset_capture");
        holdCycles(3, "midreset_steps");
        applyStimulus(1'b1, 32'd30, 32'd10, "midreset_reset");
        checkValue("midreset_zero", 32'd0);
        applyStimulus(1'b0, 32'd45, 32'd10, "midreset_a");
        applyStimulus(1'b0, 32'd45, 32'd15, "midreset_b");
        holdCycles(9, "midreset_wait");
        checkValue("midreset_value", 32'd0);

        // Divide by zero and large operands
        applyStimulus(1'b0, 32'h12345678, 32'd0, "divzero");
        holdCycles(9, "divzero_wait");
        checkValue("divzero_value", 32'h12345678);
        applyStimulus(1'b0, 32'hFFFFFFFF, 32'h80000001, "large");
        holdCycles(9, "large_wait");
        checkValue("large_value", 32'h7FFFFFFE);
        applyStimulus(1'b0, 32'd5, 32'd7, "small");
        holdCycles(9, "small_wait");
        checkValue("small_value", 32'd5);

        // Hold: 100 mod 7 must appear once and never retrigger
        changes = 0;
        prev    = result;
        applyStimulus(1'b0, 32'd100, 32'd7, "hold_capture");
        for (int i = 0; i < 30; i++) begin
            if (result !== prev) changes++;
            prev = result;
            applyStimulus(1'b0, 32'd100, 32'd7, "hold");
        end
        checkValue("hold_value", 32'd2);
        checks++;
        assert (changes == 1) else begin
            errors++;
            $error("FAIL hold_changes: changes=%0d expected=1", changes);
        end
        applyStimulus(1'b0, 32'd100, 32'd9, "b2b_a");
        holdCycles(9, "b2b_a_wait");
        checkValue("b2b_a_value", 32'd1);
        applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, "b2b_b");
        holdCycles(9, "b2b_b_wait");
        checkValue("b2b_b_value", 32'd0);

        // Random operands with random hold times, including early restarts and rare resets
        for (int n = 0; n < 60; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 255);
                2:       rb = $urandom;
                default: rb = $urandom | 32'h80000000;
            endcase
            hold = $urandom_range(1, 11);
            applyStimulus(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, ra, rb, "rand_capture");
            holdCycles(hold, "rand");
        end
        holdCycles(10, "rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
